// File: rtl/trap_sequencer.sv
// Machine-mode trap/interrupt sequencer: arbitrates enabled interrupts
// and steps trap entry and mret return through stall, flush, CSR write, redirect.
module trap_sequencer #(
  parameter int DRAIN_CYCLES = 2,
  parameter bit VECTORED_EN  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        irq_ext_i,
  input  logic        irq_sw_i,
  input  logic        irq_timer_i,
  input  logic [31:0] mie_i,
  input  logic [31:0] mstatus_i,
  input  logic [31:0] mtvec_i,
  input  logic [31:0] mepc_i,
  input  logic [31:0] pc_i,
  input  logic        pipe_valid_i,
  input  logic        is_mret_i,
  output logic [31:0] mip_o,
  output logic        stall_o,
  output logic        flush_o,
  output logic        redirect_o,
  output logic [31:0] redirect_pc_o,
  output logic        mepc_we_o,
  output logic [31:0] mepc_wdata_o,
  output logic        mcause_we_o,
  output logic [31:0] mcause_wdata_o,
  output logic        mstatus_we_o,
  output logic [31:0] mstatus_wdata_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {
    S_IDLE, S_DRAIN, S_TRAP, S_RET
  } state_e;

  localparam logic [3:0] LAST = 4'(DRAIN_CYCLES - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  code_q, code_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] mip_q;
  logic [31:0] pend;
  logic [31:0] base;
  logic        take;
  logic        vec;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      code_q  <= '0;
      pc_q    <= '0;
      mip_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      pc_q    <= pc_d;
      mip_q   <= '0;
      mip_q[11] <= irq_ext_i;
      mip_q[3]  <= irq_sw_i;
      mip_q[7]  <= irq_timer_i;
    end
  end

  assign mip_o = mip_q;
  assign pend  = mip_q & mie_i & 32'h0000_0888;
  assign take  = mstatus_i[3] & pipe_valid_i & (|pend);
  assign base  = mtvec_i & 32'hFFFF_FFFC;
  assign vec   = VECTORED_EN && (mtvec_i[1:0] == 2'b01);

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    code_d          = code_q;
    pc_d            = pc_q;
    stall_o         = 1'b0;
    flush_o         = 1'b0;
    redirect_o      = 1'b0;
    redirect_pc_o   = '0;
    mepc_we_o       = 1'b0;
    mepc_wdata_o    = '0;
    mcause_we_o     = 1'b0;
    mcause_wdata_o  = '0;
    mstatus_we_o    = 1'b0;
    mstatus_wdata_o = '0;
    busy_o          = 1'b0;
    // Outputs held quiet while reset is asserted so no half sequence escapes
    if (!rst) begin
      case (state_q)
        S_IDLE: begin
          if (take) begin
            flush_o = 1'b1;
            pc_d    = pc_i;
            cnt_d   = '0;
            state_d = S_DRAIN;
            if (pend[11])     code_d = 4'd11;
            else if (pend[3]) code_d = 4'd3;
            else              code_d = 4'd7;
          end else if (is_mret_i && pipe_valid_i) begin
            flush_o = 1'b1;
            state_d = S_RET;
          end
        end
        S_DRAIN: begin
          stall_o = 1'b1;
          busy_o  = 1'b1;
          if (cnt_q == LAST) state_d = S_TRAP;
          else               cnt_d   = cnt_q + 4'd1;
        end
        S_TRAP: begin
          stall_o            = 1'b1;
          busy_o             = 1'b1;
          mepc_we_o          = 1'b1;
          mepc_wdata_o       = pc_q;
          mcause_we_o        = 1'b1;
          mcause_wdata_o     = {1'b1, 27'b0, code_q};
          mstatus_we_o       = 1'b1;
          mstatus_wdata_o    = mstatus_i;
          mstatus_wdata_o[7] = mstatus_i[3];
          mstatus_wdata_o[3] = 1'b0;
          redirect_o         = 1'b1;
          redirect_pc_o      = vec ? base + {26'b0, code_q, 2'b0}
                                   : base;
          state_d            = S_IDLE;
        end
        S_RET: begin
          stall_o            = 1'b1;
          busy_o             = 1'b1;
          mstatus_we_o       = 1'b1;
          mstatus_wdata_o    = mstatus_i;
          mstatus_wdata_o[3] = mstatus_i[7];
          mstatus_wdata_o[7] = 1'b1;
          redirect_o         = 1'b1;
          redirect_pc_o      = mepc_i & 32'hFFFF_FFFC;
          state_d            = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

endmodule
